// File: rtl/side_servo_pkg.sv
// side_servo_pkg: shared constants for the side-servo AXI register block.
//   Register word offsets (addr[3:2]), the CTRL enable bit position,
//   the AXI response type and a byte-strobe merge helper.
package side_servo_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PULSE   = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/side_servo_pwm_gen.sv
// side_servo_pwm_gen: servo PWM generator with period-boundary shadowing.
//   clk, rst_n      clock, async active-low reset
//   enable          run the prescaler/counter; low holds everything at 0
//   pulse, period   requested high time and period, in ticks
//   servo_pwm       pulse output, high while count < min(pulse, period)
//   period_start    one-cycle strobe in the first cycle of each period
module side_servo_pwm_gen #(
    parameter int CLK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] pulse,
    input  logic [31:0] period,
    output logic        servo_pwm,
    output logic        period_start
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] presc;
    logic [31:0]   cnt;
    logic [31:0]   sh_pulse;
    logic [31:0]   sh_period;
    logic          armed;
    logic          tick;
    logic          boundary;

    assign tick = presc == PW'(CLK_DIV - 1);
    // armed marks the first tick after enable; a zero period reloads every tick
    assign boundary = armed || sh_period == 32'd0 || cnt == sh_period - 32'd1;
    assign servo_pwm = cnt < (sh_pulse < sh_period ? sh_pulse : sh_period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !enable) begin
            presc        <= '0;
            cnt          <= '0;
            sh_pulse     <= '0;
            sh_period    <= '0;
            armed        <= 1'b1;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + PW'(1);
            period_start <= tick && boundary;
            if (tick) begin
                if (boundary) begin
                    cnt       <= '0;
                    sh_pulse  <= pulse;
                    sh_period <= period;
                    armed     <= 1'b0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/side_servo_axi_regs.sv
// side_servo_axi_regs: AXI4-Lite slave holding CTRL/PULSE/PERIOD/SCRATCH and driving the servo PWM.
//   s00_axi_*      AXI4-Lite slave channels (AW, W, B, AR, R); prot inputs are ignored
//   servo_pwm      servo pulse output
//   period_start   one-cycle strobe at each PWM period boundary
module side_servo_axi_regs
    import side_servo_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CLK_DIV            = 100
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            servo_pwm,
    output logic                            period_start
);

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic [1:0] rd_sel;
    logic       wr_go;
    logic       rd_go;
    logic       wr_en;
    logic       unused_ok;

    // Accept AW and W only together, and only while no response is pending.
    assign wr_go = s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready;
    assign rd_go = s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
    assign wr_en = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;

    assign s00_axi_bresp = RESP_OKAY;
    assign s00_axi_rresp = RESP_OKAY;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            rd_sel          <= '0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            s00_axi_awready <= wr_go;
            s00_axi_wready  <= wr_go;
            if (wr_en)
                s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready)
                s00_axi_bvalid <= 1'b0;
            if (wr_en)
                regs[s00_axi_awaddr[3:2]] <= strb_merge(regs[s00_axi_awaddr[3:2]], s00_axi_wdata, s00_axi_wstrb);
            s00_axi_arready <= rd_go;
            if (rd_go)
                rd_sel <= s00_axi_araddr[3:2];
            // rdata samples the register before any same-edge write lands
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= regs[rd_sel];
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    side_servo_pwm_gen #(.CLK_DIV(CLK_DIV)) u_pwm (
        .clk          (s00_axi_aclk),
        .rst_n        (s00_axi_aresetn),
        .enable       (regs[REG_CTRL][CTRL_ENABLE_BIT]),
        .pulse        (regs[REG_PULSE]),
        .period       (regs[REG_PERIOD]),
        .servo_pwm    (servo_pwm),
        .period_start (period_start)
    );

endmodule
